// File: rtl/pin_edge_detector_if.sv
// Pin-side signal bundle for pin_edge_detector: raw asynchronous level in,
// synchronised level and edge pulses out.
interface pin_edge_detector_if;
    logic level;
    logic level_sync;
    logic pos_edge;
    logic neg_edge;
    logic any_edge;

    modport master (
        output level,
        input  level_sync,
        input  pos_edge,
        input  neg_edge,
        input  any_edge
    );

    modport slave (
        input  level,
        output level_sync,
        output pos_edge,
        output neg_edge,
        output any_edge
    );
endinterface

// File: rtl/pin_edge_detector.sv
// Synchronising edge detector for an asynchronous pin; optional glitch filter
// enabled by defining EDGE_DETECTOR_FILTER_EN.
module pin_edge_detector #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          RESET_LEVEL   = 1'b1,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    pin_edge_detector_if.slave pins
);

    generate
        if (SYNC_STAGES < 1 || SYNC_STAGES > 4 ||
            FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_cfg
            $error("pin_edge_detector: parameter out of legal range");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   level_p1;
    logic                   prev_p2;
    logic                   pos_p2;
    logic                   neg_p2;
    logic                   any_p2;

    // Stage 0: metastability chain; reset loads the idle level so release is quiet
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_p0[0] <= pins.level;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p0[i] <= sync_p0[i-1];
            end
        end
    end

    // Stage 1: optional glitch filter producing the level seen by the edge stage
`ifdef EDGE_DETECTOR_FILTER_EN
    localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 1);

    logic [7:0] filt_cnt_p1;
    logic       filt_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_p1     <= RESET_LEVEL;
            filt_cnt_p1 <= 8'd0;
        end else if (sync_p0[SYNC_STAGES-1] == filt_p1) begin
            filt_cnt_p1 <= 8'd0;
        end else if (filt_cnt_p1 == FILT_LAST) begin
            filt_p1     <= sync_p0[SYNC_STAGES-1];
            filt_cnt_p1 <= 8'd0;
        end else begin
            filt_cnt_p1 <= filt_cnt_p1 + 8'd1;
        end
    end

    assign level_p1 = filt_p1;
`else
    assign level_p1 = sync_p0[SYNC_STAGES-1];
`endif

    // Stage 2: registered edge pulses, one cycle per transition of level_p1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_p2 <= RESET_LEVEL;
            pos_p2  <= 1'b0;
            neg_p2  <= 1'b0;
            any_p2  <= 1'b0;
        end else begin
            prev_p2 <= level_p1;
            pos_p2  <= level_p1 & ~prev_p2;
            neg_p2  <= ~level_p1 & prev_p2;
            any_p2  <= level_p1 ^ prev_p2;
        end
    end

    assign pins.level_sync = level_p1;
    assign pins.pos_edge   = pos_p2;
    assign pins.neg_edge   = neg_p2;
    assign pins.any_edge   = any_p2;

endmodule

// File: tb/tb_pin_edge_detector.sv
// Randomised self-checking bench for pin_edge_detector against an edge-indexed
// history model of the pin.
module tb_pin_edge_detector;
    localparam int S  = 2;
    localparam bit RL = 1'b1;
    localparam int F  = 4;
`ifdef EDGE_DETECTOR_FILTER_EN
    localparam int FLT = F;
`else
    localparam int FLT = 0;
`endif
    localparam int LAT = S + FLT;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pin_edge_detector_if pins ();

    pin_edge_detector #(
        .SYNC_STAGES  (S),
        .RESET_LEVEL  (RL),
        .FILTER_CYCLES(F)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pins (pins)
    );

    int vectors     = 0;
    int miscompares = 0;

    // lvl_h[n]: pin value captured at clock edge n after reset release.
    // ls_h[n]:  expected level_sync right after edge n.
    bit lvl_h[$];
    bit ls_h[$];

    function automatic bit raw_at(int n);
        if (n < S - 1) return RL;
        return lvl_h[n - S + 1];
    endfunction

    function automatic bit ls_at(int n);
        if (n < 0) return RL;
        return ls_h[n];
    endfunction

    function automatic void model_edge();
        int n;
        bit cur;
        bit nxt;
        n   = lvl_h.size() - 1;
        cur = ls_at(n - 1);
`ifdef EDGE_DETECTOR_FILTER_EN
        nxt = ~cur;
        for (int j = 1; j <= F; j++) begin
            if (raw_at(n - j) == cur) nxt = cur;
        end
`else
        nxt = raw_at(n);
`endif
        ls_h.push_back(nxt);
    endfunction

    function automatic logic [3:0] expected();
        int n;
        bit a;
        bit b;
        n = lvl_h.size() - 1;
        a = ls_at(n - 1);
        b = ls_at(n - 2);
        return {ls_at(n), a & ~b, ~a & b, a ^ b};
    endfunction

    function automatic logic [3:0] observed();
        return {pins.level_sync, pins.pos_edge, pins.neg_edge, pins.any_edge};
    endfunction

    // Called at a falling edge; the value is captured by the next rising edge.
    task automatic drive(input bit lv);
        pins.level = lv;
        lvl_h.push_back(lv);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_model();
        lvl_h.delete();
        ls_h.delete();
    endtask

    task automatic test_reset();
        logic [3:0] got;
        pins.level = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        got = observed();
        vectors++;
        if (got !== {RL, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_async: got %b want %b", got, {RL, 3'b000});
        end
        repeat (2) @(negedge clk);
        got = observed();
        vectors++;
        if (got !== {RL, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_held: got %b want %b", got, {RL, 3'b000});
        end
        reset = 1'b0;
        clear_model();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1);
            got = observed();
            vectors++;
            if (got !== 4'b1000) begin
                miscompares++;
                $display("FAIL reset_idle cyc%0d: got %b want %b", i, got, 4'b1000);
            end
        end
    endtask

    task automatic test_fall_edge();
        logic [3:0] got;
        logic [3:0] exp;
        for (int m = 0; m <= LAT + 3; m++) begin
            drive(1'b0);
            got = observed();
            exp = expected();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL fall_model m%0d: got %b want %b", m, got, exp);
            end
            if (m == LAT) begin
                vectors++;
                if (got !== 4'b0011) begin
                    miscompares++;
                    $display("FAIL fall_latency: got %b want %b", got, 4'b0011);
                end
            end
            if (m == LAT + 1) begin
                vectors++;
                if (got !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL fall_width: got %b want %b", got, 4'b0000);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        logic [3:0] exp;
        for (int m = 0; m < LAT + 3; m++) begin
            drive(1'b1);
            got = observed();
            exp = expected();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL b2b_rise m%0d: got %b want %b", m, got, exp);
            end
        end
        drive(1'b0);
        for (int i = 1; i <= LAT + 4; i++) begin
            drive(1'b1);
            got = observed();
            exp = expected();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL b2b_model i%0d: got %b want %b", i, got, exp);
            end
`ifndef EDGE_DETECTOR_FILTER_EN
            if (i == S) begin
                vectors++;
                if (got !== 4'b1011) begin
                    miscompares++;
                    $display("FAIL b2b_neg: got %b want %b", got, 4'b1011);
                end
            end
            if (i == S + 1) begin
                vectors++;
                if (got !== 4'b1101) begin
                    miscompares++;
                    $display("FAIL b2b_pos: got %b want %b", got, 4'b1101);
                end
            end
`endif
        end
    endtask

    task automatic test_reset_release_low();
        logic [3:0] got;
        logic [3:0] exp;
        reset      = 1'b1;
        pins.level = 1'b0;
        #1;
        got = observed();
        vectors++;
        if (got !== {RL, 3'b000}) begin
            miscompares++;
            $display("FAIL rel_low_reset: got %b want %b", got, {RL, 3'b000});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
        for (int m = 0; m <= LAT + 4; m++) begin
            drive(1'b0);
            got = observed();
            exp = expected();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rel_low_model m%0d: got %b want %b", m, got, exp);
            end
            if (m == LAT) begin
                vectors++;
                if (got !== 4'b0011) begin
                    miscompares++;
                    $display("FAIL rel_low_pulse: got %b want %b", got, 4'b0011);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [3:0] got;
        logic [3:0] exp;
        for (int m = 0; m < LAT + 4; m++) begin
            drive(1'b1);
            got = observed();
            exp = expected();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL mid_prep m%0d: got %b want %b", m, got, exp);
            end
        end
        for (int m = 0; m <= LAT; m++) drive(1'b0);
        got = observed();
        vectors++;
        if (got !== 4'b0011) begin
            miscompares++;
            $display("FAIL mid_pulse_seen: got %b want %b", got, 4'b0011);
        end
        reset      = 1'b1;
        pins.level = 1'b1;
        #1;
        got = observed();
        vectors++;
        if (got !== {RL, 3'b000}) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got %b want %b", got, {RL, 3'b000});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
        for (int m = 0; m < LAT + 4; m++) begin
            drive(1'b1);
            got = observed();
            vectors++;
            if (got !== 4'b1000) begin
                miscompares++;
                $display("FAIL mid_after m%0d: got %b want %b", m, got, 4'b1000);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] got;
        logic [3:0] exp;
        bit lv;
        int run;
        int cyc;
        lv  = 1'b1;
        cyc = 0;
        while (cyc < 400) begin
            lv  = ~lv;
            run = $urandom_range(1, 8);
            for (int r = 0; r < run; r++) begin
                drive(lv);
                cyc++;
                got = observed();
                exp = expected();
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL random c%0d: got %b want %b", cyc, got, exp);
                end
                vectors++;
                if (pins.pos_edge === 1'b1 && pins.neg_edge === 1'b1) begin
                    miscompares++;
                    $display("FAIL random_excl c%0d: got pos=1 neg=1 want not both", cyc);
                end
            end
        end
    endtask

`ifdef EDGE_DETECTOR_FILTER_EN
    task automatic test_filter();
        logic [3:0] got;
        logic [3:0] exp;
        for (int m = 0; m < LAT + 4; m++) drive(1'b1);
        for (int m = 0; m < 3 + LAT + 4; m++) begin
            drive(m < 3 ? 1'b0 : 1'b1);
            got = observed();
            vectors++;
            if (got !== 4'b1000) begin
                miscompares++;
                $display("FAIL filt_glitch m%0d: got %b want %b", m, got, 4'b1000);
            end
        end
        for (int m = 0; m < 4 + LAT + 4; m++) begin
            drive(m < 4 ? 1'b0 : 1'b1);
            got = observed();
            exp = expected();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL filt_model m%0d: got %b want %b", m, got, exp);
            end
            if (m == S + F) begin
                vectors++;
                if (got[1:0] !== 2'b11 || got[2] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL filt_neg: got %b want x011", got);
                end
            end
        end
    endtask
`endif

    initial begin
        pins.level = 1'b1;
        test_reset();
        test_fall_edge();
        test_back_to_back();
        test_reset_release_low();
        test_reset_mid_pulse();
        test_random();
`ifdef EDGE_DETECTOR_FILTER_EN
        test_filter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
